// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - game flow state encoding and default frame counts
package vgaPkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_INTRO = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam int INTRO_FRAMES_DEF = 120;
  localparam int OVER_FRAMES_DEF  = 180;

  // Frame counter width; never below one bit so a 1-frame phase still has a counter.
  function automatic int frame_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - game sequencer signal bundle; master is the game/timing side
interface game_sequencer_if;
  logic       vblnk;
  logic       start_btn;
  logic       pause_btn;
  logic       win;
  logic       lose;
  logic       start_game;
  logic       animation;
  logic       game_over;
  logic       result;
  logic       frame_tick;
  logic [2:0] state;

  modport master (
    output vblnk, start_btn, pause_btn, win, lose,
    input  start_game, animation, game_over, result, frame_tick, state
  );

  modport slave (
    input  vblnk, start_btn, pause_btn, win, lose,
    output start_game, animation, game_over, result, frame_tick, state
  );
endinterface

// File: rtl/game_sequencer_btn_edge_sync.sv
// rtl/game_sequencer_btn_edge_sync.sv - 2-flop synchronizer plus registered rising-edge pulse
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - menu/intro/play/over flow paced by vblank frame ticks
// GAME_PAUSE_EN adds the PAUSE state and the pause button path.
module game_sequencer
  import vgaPkg::*;
#(
  parameter int INTRO_FRAMES = INTRO_FRAMES_DEF,
  parameter int OVER_FRAMES  = OVER_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  gs
);

  localparam int CNT_W = frame_cnt_width(INTRO_FRAMES, OVER_FRAMES);
  localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);

  logic start_p;
  logic pause_p;

  btn_edge_sync u_start_sync (
    .clk   (clk),
    .rst_n (rst),
    .btn   (gs.start_btn),
    .pulse (start_p)
  );

`ifdef GAME_PAUSE_EN
  btn_edge_sync u_pause_sync (
    .clk   (clk),
    .rst_n (rst),
    .btn   (gs.pause_btn),
    .pulse (pause_p)
  );
`else
  assign pause_p = 1'b0;
`endif

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             result_q, result_d;
  logic             vblnk_q, vblnk_d;
  logic             frame_tick_q, frame_tick_d;
  logic             start_game_q, start_game_d;
  logic             animation_q, animation_d;
  logic             game_over_q, game_over_d;

  always_comb begin
    vblnk_d      = gs.vblnk;
    frame_tick_d = gs.vblnk & ~vblnk_q;
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    result_d     = result_q;

    case (state_q)
      ST_MENU: begin
        if (start_p) begin
          state_d     = ST_INTRO;
          frame_cnt_d = '0;
        end
      end
      ST_INTRO: begin
        if (frame_tick_q) begin
          if (frame_cnt_q == INTRO_LAST) begin
            state_d     = ST_PLAY;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // lose dominates a simultaneous win
        if (gs.win || gs.lose) begin
          state_d     = ST_OVER;
          result_d    = ~gs.lose;
          frame_cnt_d = '0;
        end else if (pause_p) begin
          state_d = ST_PAUSE;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pause_p) begin
          state_d = ST_PLAY;
        end
      end
`endif
      ST_OVER: begin
        if (frame_tick_q) begin
          if (frame_cnt_q == OVER_LAST) begin
            state_d     = ST_MENU;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_MENU;
        frame_cnt_d = '0;
      end
    endcase

    // Outputs decoded from the next state so they line up with state_q.
    start_game_d = (state_d != ST_MENU);
    animation_d  = (state_d == ST_INTRO);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_MENU;
      frame_cnt_q  <= '0;
      result_q     <= 1'b0;
      vblnk_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      start_game_q <= 1'b0;
      animation_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      result_q     <= result_d;
      vblnk_q      <= vblnk_d;
      frame_tick_q <= frame_tick_d;
      start_game_q <= start_game_d;
      animation_q  <= animation_d;
      game_over_q  <= game_over_d;
    end
  end

  assign gs.start_game = start_game_q;
  assign gs.animation  = animation_q;
  assign gs.game_over  = game_over_q;
  assign gs.result     = result_q;
  assign gs.frame_tick = frame_tick_q;
  assign gs.state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized game-flow bench against an event-level model
module tb_game_sequencer;

  localparam int INTRO = 3;
  localparam int OVER  = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   tick_count;

  int m_state;
  int m_result;
  int m_cnt;

  game_sequencer_if gs_if ();

  game_sequencer #(
    .INTRO_FRAMES (INTRO),
    .OVER_FRAMES  (OVER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gs  (gs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial tick_count = 0;
  always @(negedge clk) if (gs_if.frame_tick === 1'b1) tick_count++;

  // Event-level reference: phase plus frames seen since entering it.
  task automatic model_reset();
    m_state = 0; m_result = 0; m_cnt = 0;
  endtask

  task automatic model_start();
    if (m_state == 0) begin m_state = 1; m_cnt = 0; end
  endtask

  task automatic model_frame();
    if (m_state == 1 || m_state == 4) begin
      m_cnt++;
      if (m_state == 1 && m_cnt == INTRO) begin m_state = 2; m_cnt = 0; end
      else if (m_state == 4 && m_cnt == OVER) begin m_state = 0; m_cnt = 0; end
    end
  endtask

  task automatic model_event(input bit w, input bit l);
    if (m_state == 2 && (w || l)) begin
      m_state = 4; m_result = l ? 0 : 1; m_cnt = 0;
    end
  endtask

  task automatic model_pause();
    if (m_state == 2) m_state = 3;
    else if (m_state == 3) m_state = 2;
  endtask

  task automatic do_start();
    @(posedge clk); #1 gs_if.start_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1 gs_if.start_btn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_pause();
    @(posedge clk); #1 gs_if.pause_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1 gs_if.pause_btn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    @(posedge clk); #1 gs_if.vblnk = 1'b1;
    repeat (2) @(posedge clk);
    #1 gs_if.vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_event(input bit w, input bit l);
    @(posedge clk); #1 gs_if.win = w; gs_if.lose = l;
    @(posedge clk); #1 gs_if.win = 1'b0; gs_if.lose = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.start_game !== 1'b0 || gs_if.animation !== 1'b0 ||
        gs_if.game_over !== 1'b0 || gs_if.result !== 1'b0 || gs_if.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: state=%0d sg=%b an=%b go=%b res=%b ft=%b, required all 0",
               gs_if.state, gs_if.start_game, gs_if.animation, gs_if.game_over, gs_if.result,
               gs_if.frame_tick);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gs_if.state !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: state=%0d required 0", gs_if.state);
    end
    model_reset();
  endtask

  task automatic test_start_latency();
    int t0;
    t0 = tick_count;
    @(posedge clk); #1 gs_if.start_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.start_game !== 1'b0) begin
      failures++;
      $display("FAIL start_early: state=%0d sg=%b, required 0/0 three cycles after press",
               gs_if.state, gs_if.start_game);
    end
    @(posedge clk); #1;
    checks++;
    if (gs_if.state !== 3'd1 || gs_if.start_game !== 1'b1 || gs_if.animation !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: state=%0d sg=%b an=%b, required 1/1/1 four cycles after press",
               gs_if.state, gs_if.start_game, gs_if.animation);
    end
    repeat (96) @(posedge clk);
    #1 gs_if.start_btn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    model_start();
    checks++;
    if (gs_if.state !== 3'd1 || gs_if.animation !== 1'b1 || tick_count != t0) begin
      failures++;
      $display("FAIL start_held: state=%0d an=%b ticks=%0d, required state 1 an 1 ticks 0",
               gs_if.state, gs_if.animation, tick_count - t0);
    end
  endtask

  task automatic test_intro_frames();
    int t0;
    t0 = tick_count;
    @(posedge clk); #1 gs_if.vblnk = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gs_if.frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_rise: frame_tick=%b required 1", gs_if.frame_tick);
    end
    @(posedge clk); #1;
    checks++;
    if (gs_if.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_width: frame_tick=%b required 0 on second cycle", gs_if.frame_tick);
    end
    gs_if.vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_frame();
    do_frame();
    model_frame();
    checks++;
    if (gs_if.animation !== 1'b1 || gs_if.state !== 3'd1) begin
      failures++;
      $display("FAIL intro_not_done: an=%b state=%0d, required 1/1 after %0d ticks",
               gs_if.animation, gs_if.state, INTRO - 1);
    end
    do_frame();
    model_frame();
    checks++;
    if (tick_count - t0 != INTRO || gs_if.animation !== 1'b0 || gs_if.state !== 3'd2) begin
      failures++;
      $display("FAIL intro_done: ticks=%0d an=%b state=%0d, required %0d/0/2",
               tick_count - t0, gs_if.animation, gs_if.state, INTRO);
    end
  endtask

  task automatic test_win_lose_same();
    do_event(1'b1, 1'b1);
    model_event(1'b1, 1'b1);
    checks++;
    if (gs_if.state !== 3'd4 || gs_if.game_over !== 1'b1 || gs_if.result !== 1'b0) begin
      failures++;
      $display("FAIL both_pulse: state=%0d go=%b res=%b, required 4/1/0",
               gs_if.state, gs_if.game_over, gs_if.result);
    end
    repeat (OVER) begin do_frame(); model_frame(); end
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.start_game !== 1'b0) begin
      failures++;
      $display("FAIL over_to_menu: state=%0d sg=%b, required 0/0", gs_if.state, gs_if.start_game);
    end
  endtask

  task automatic test_win_hold();
    do_start(); model_start();
    repeat (INTRO) begin do_frame(); model_frame(); end
    do_event(1'b1, 1'b0);
    model_event(1'b1, 1'b0);
    checks++;
    if (gs_if.state !== 3'd4 || gs_if.result !== 1'b1 || gs_if.game_over !== 1'b1) begin
      failures++;
      $display("FAIL win_result: state=%0d res=%b go=%b, required 4/1/1",
               gs_if.state, gs_if.result, gs_if.game_over);
    end
    do_frame(); model_frame();
    checks++;
    if (gs_if.state !== 3'd4) begin
      failures++;
      $display("FAIL over_hold: state=%0d required 4 after %0d tick", gs_if.state, OVER - 1);
    end
    do_frame(); model_frame();
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.result !== 1'b1) begin
      failures++;
      $display("FAIL result_kept: state=%0d res=%b, required 0/1", gs_if.state, gs_if.result);
    end
  endtask

  task automatic test_reset_mid_play();
    do_start(); model_start();
    repeat (INTRO) begin do_frame(); model_frame(); end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.start_game !== 1'b0 || gs_if.animation !== 1'b0 ||
        gs_if.game_over !== 1'b0 || gs_if.result !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: state=%0d sg=%b an=%b go=%b res=%b, required all 0",
               gs_if.state, gs_if.start_game, gs_if.animation, gs_if.game_over, gs_if.result);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (gs_if.state !== 3'd0 || gs_if.start_game !== 1'b0) begin
      failures++;
      $display("FAIL reset_menu: state=%0d sg=%b, required 0/0", gs_if.state, gs_if.start_game);
    end
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    do_start(); model_start();
    repeat (INTRO) begin do_frame(); model_frame(); end
    do_pause(); model_pause();
    checks++;
    if (gs_if.state !== 3'd3 || gs_if.start_game !== 1'b1) begin
      failures++;
      $display("FAIL pause_enter: state=%0d sg=%b, required 3/1", gs_if.state, gs_if.start_game);
    end
    do_event(1'b1, 1'b0);
    model_event(1'b1, 1'b0);
    checks++;
    if (gs_if.state !== 3'd3 || gs_if.game_over !== 1'b0) begin
      failures++;
      $display("FAIL pause_win_ignored: state=%0d go=%b, required 3/0", gs_if.state, gs_if.game_over);
    end
    do_pause(); model_pause();
    checks++;
    if (gs_if.state !== 3'd2) begin
      failures++;
      $display("FAIL pause_exit: state=%0d required 2", gs_if.state);
    end
  endtask
`endif

  task automatic test_random();
    int op;
    int top_op;
`ifdef GAME_PAUSE_EN
    top_op = 5;
`else
    top_op = 4;
`endif
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, top_op);
      case (op)
        0: begin do_start(); model_start(); end
        1, 2: begin do_frame(); model_frame(); end
        3: begin
          int w;
          int l;
          w = $urandom_range(0, 1);
          l = (w == 0) ? 1 : $urandom_range(0, 1);
          do_event(w[0], l[0]);
          model_event(w[0], l[0]);
          repeat (2) @(posedge clk);
          #1;
        end
        4: begin repeat ($urandom_range(1, 5)) @(posedge clk); #1; end
        default: begin do_pause(); model_pause(); end
      endcase
      checks++;
      if (gs_if.state !== 3'(m_state) || gs_if.result !== 1'(m_result) ||
          gs_if.start_game !== (m_state != 0) || gs_if.animation !== (m_state == 1) ||
          gs_if.game_over !== (m_state == 4)) begin
        failures++;
        $display("FAIL random_op%0d_step%0d: state=%0d res=%b sg=%b an=%b go=%b, required state=%0d res=%0d",
                 op, i, gs_if.state, gs_if.result, gs_if.start_game, gs_if.animation,
                 gs_if.game_over, m_state, m_result);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    gs_if.vblnk = 1'b0;
    gs_if.start_btn = 1'b0;
    gs_if.pause_btn = 1'b0;
    gs_if.win = 1'b0;
    gs_if.lose = 1'b0;
    model_reset();
    test_reset();
    test_start_latency();
    test_intro_frames();
    test_win_lose_same();
    test_win_hold();
    test_reset_mid_play();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
